// File: rtl/macguffin_key_mix_if.sv
// Handshake bundle for the MacGuffin key-mixing stage.
// slave = the stage itself, master = the upstream/downstream side driving it.
interface macguffin_key_mix_if #(
  parameter int RND_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_block;
  logic [47:0]      in_key;
  logic [RND_W-1:0] in_round;
  logic             out_valid;
  logic             out_ready;
  logic [47:0]      out_data;
  logic [63:0]      out_block;
  logic [RND_W-1:0] out_round;
  logic             out_last;

  modport master (
    output in_valid,
    output in_block,
    output in_key,
    output in_round,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_block,
    input  out_round,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_block,
    input  in_key,
    input  in_round,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_block,
    output out_round,
    output out_last
  );
endinterface

// File: rtl/macguffin_key_mix.sv
// MacGuffin key-mix stage: XOR control words with round key, 2-entry skid FIFO.
// Optional MACGUFFIN_KEY_MIX_ZEROIZE_EN clears entries on pop/flush.
module macguffin_key_mix #(
  parameter int ROUNDS = 32,
  parameter int RND_W  = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  macguffin_key_mix_if.slave   bus
);

  typedef struct packed {
    logic [47:0]      data;
    logic [63:0]      block;
    logic [RND_W-1:0] rnd;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL1 = 2'd1,
    FULL2 = 2'd2
  } state_e;

  localparam logic [RND_W-1:0] LAST_RND = RND_W'(ROUNDS - 1);

`ifdef MACGUFFIN_KEY_MIX_ZEROIZE_EN
  localparam bit ZEROIZE = 1'b1;
`else
  localparam bit ZEROIZE = 1'b0;
`endif

  state_e state_q, state_d;
  entry_t head_q, head_d;
  entry_t tail_q, tail_d;
  logic   in_ready_q, in_ready_d;
  logic   push, pop;
  entry_t beat;

  // R0 is the target word and rides along unmixed in the block
  always_comb begin
    beat.data  = {bus.in_block[47:32] ^ bus.in_key[47:32],
                  bus.in_block[31:16] ^ bus.in_key[31:16],
                  bus.in_block[15:0]  ^ bus.in_key[15:0]};
    beat.block = bus.in_block;
    beat.rnd   = bus.in_round;
  end

  assign push = bus.in_valid && in_ready_q && !flush;
  assign pop  = (state_q != EMPTY) && bus.out_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= in_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = EMPTY;
      if (ZEROIZE) begin
        head_d = '0;
        tail_d = '0;
      end
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = FULL1;
            head_d  = beat;
          end
        end
        FULL1: begin
          case ({push, pop})
            2'b11: head_d = beat;
            2'b10: begin
              tail_d  = beat;
              state_d = FULL2;
            end
            2'b01: begin
              state_d = EMPTY;
              if (ZEROIZE) head_d = '0;
            end
            default: ;
          endcase
        end
        FULL2: begin
          if (pop) begin
            head_d  = tail_q;
            state_d = FULL1;
            if (ZEROIZE) tail_d = '0;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
    // Registered so upstream sees a clean flop; low for one cycle after flush
    in_ready_d = (state_d != FULL2) && !flush;
  end

  always_comb begin
    bus.in_ready  = in_ready_q;
    bus.out_valid = (state_q != EMPTY);
    bus.out_data  = head_q.data;
    bus.out_block = head_q.block;
    bus.out_round = head_q.rnd;
    bus.out_last  = (head_q.rnd == LAST_RND);
  end

endmodule

// File: tb/tb_macguffin_key_mix.sv
// Randomized bench for macguffin_key_mix against a queue-based model.
// Model: beats in flight are a queue; ready = room left and no flush last cycle.
module tb_macguffin_key_mix;

  localparam int ROUNDS = 32;
  localparam int RND_W  = 5;

  typedef struct {
    logic [63:0]      blk;
    logic [47:0]      key;
    logic [RND_W-1:0] rnd;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  macguffin_key_mix_if #(.RND_W(RND_W)) bus ();

  macguffin_key_mix #(
    .ROUNDS(ROUNDS),
    .RND_W (RND_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int    n_chk  = 0;
  int    n_pass = 0;
  beat_t q[$];
  bit    mrdy = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [47:0] mix(input beat_t b);
    logic [15:0] r1, r2, r3, k0, k1, k2;
    r1 = b.blk[47:32]; r2 = b.blk[31:16]; r3 = b.blk[15:0];
    k0 = b.key[47:32]; k1 = b.key[31:16]; k2 = b.key[15:0];
    return {r1 ^ k0, r2 ^ k1, r3 ^ k2};
  endfunction

  task automatic drive(input bit v, input logic [63:0] blk,
                       input logic [47:0] key, input int rnd);
    bus.in_valid = v;
    bus.in_block = blk;
    bus.in_key   = key;
    bus.in_round = RND_W'(rnd);
  endtask

  task automatic drive_rand(input bit v);
    drive(v, {$urandom, $urandom}, {16'($urandom), $urandom},
          int'($urandom_range(0, 31)));
  endtask

  // Check outputs against the model, then clock one edge and update it
  task automatic step();
    beat_t cur, h;
    bit    psh, pp, fl;
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    chk("in_ready", 64'(bus.in_ready), 64'(mrdy));
    if (q.size() != 0) begin
      h = q[0];
      chk("out_data", 64'(bus.out_data), 64'(mix(h)));
      chk("out_block", bus.out_block, h.blk);
      chk("out_round", 64'(bus.out_round), 64'(h.rnd));
      chk("out_last", 64'(bus.out_last), 64'(int'(h.rnd) == ROUNDS - 1));
    end else begin
`ifdef MACGUFFIN_KEY_MIX_ZEROIZE_EN
      chk("zero_data", 64'(bus.out_data), 64'd0);
      chk("zero_block", bus.out_block, 64'd0);
      chk("zero_round", 64'(bus.out_round), 64'd0);
`endif
    end
    fl  = flush;
    psh = bus.in_valid && mrdy && !fl;
    pp  = (q.size() != 0) && bus.out_ready && !fl;
    cur.blk = bus.in_block;
    cur.key = bus.in_key;
    cur.rnd = bus.in_round;
    @(posedge clk);
    #1;
    if (fl) q.delete();
    else begin
      if (pp) void'(q.pop_front());
      if (psh) q.push_back(cur);
    end
    mrdy = (q.size() < 2) && !fl;
  endtask

  initial begin
    drive(1'b0, 64'd0, 48'd0, 0);
    bus.out_ready = 1'b0;
    #12;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_out_data", 64'(bus.out_data), 64'd0);
    chk("rst_out_block", bus.out_block, 64'd0);
    chk("rst_out_round", 64'(bus.out_round), 64'd0);
    chk("rst_out_last", 64'(bus.out_last), 64'd0);
    rst_n = 1'b1;
    step();
    step();

    // Known-answer single beat
    bus.out_ready = 1'b1;
    drive(1'b1, 64'h0123_4567_89AB_CDEF, 48'hFFFF_0000_1234, 3);
    step();
    drive(1'b0, 64'd0, 48'd0, 0);
    chk("kat_data", 64'(bus.out_data), 64'hBA98_89AB_DFDB);
    chk("kat_block", bus.out_block, 64'h0123_4567_89AB_CDEF);
    chk("kat_round", 64'(bus.out_round), 64'd3);
    step();
    step();

    // Backpressure with rounds 28..31, then drain
    bus.out_ready = 1'b0;
    for (int r = 28; r < 32; r++) begin
      drive_rand(1'b1);
      bus.in_round = RND_W'(r);
      while (!mrdy) step();
      step();
      if (r == 29) chk("bp_ready_low", 64'(bus.in_ready), 64'd0);
      if (r == 29) bus.out_ready = 1'b1;
    end
    drive(1'b0, 64'd0, 48'd0, 0);
    repeat (4) step();

    // Streaming: one beat per cycle, never filling
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_rand(1'b1);
      step();
      chk("stream_ready", 64'(bus.in_ready), 64'd1);
    end
    drive(1'b0, 64'd0, 48'd0, 0);
    step();
    step();

    // Flush while FULL2 with a beat offered
    bus.out_ready = 1'b0;
    drive_rand(1'b1);
    step();
    drive_rand(1'b1);
    step();
    drive_rand(1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_ovalid", 64'(bus.out_valid), 64'd0);
    chk("flush_iready", 64'(bus.in_ready), 64'd0);
    drive(1'b0, 64'd0, 48'd0, 0);
    bus.out_ready = 1'b1;
    step();
    chk("flush_iready_back", 64'(bus.in_ready), 64'd1);
    step();

    // Async reset mid-stream in FULL2
    bus.out_ready = 1'b0;
    drive_rand(1'b1);
    step();
    drive_rand(1'b1);
    step();
    drive(1'b0, 64'd0, 48'd0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ovalid", 64'(bus.out_valid), 64'd0);
    chk("arst_iready", 64'(bus.in_ready), 64'd0);
    q.delete();
    mrdy = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) step();

    // Random traffic with occasional flush
    for (int i = 0; i < 3000; i++) begin
      drive_rand($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 4) > 1);
      flush = ($urandom_range(0, 39) == 0);
      step();
    end
    flush = 1'b0;
    drive(1'b0, 64'd0, 48'd0, 0);
    bus.out_ready = 1'b1;
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/macguffin_key_mix.md
# macguffin_key_mix

Registered key-mixing stage of the MacGuffin round datapath, directly upstream of the 48-bit P-box. Each beat carries a 64-bit block, its 48-bit round key and a round index. The stage XORs the three control words with the round key and buffers the result, block and index in a 2-entry skid buffer. Its 48-bit `out_data` connects straight to the P-box `data` input.

## Interface
Parameters:
- `ROUNDS`, default 32: rounds per block; sets when `out_last` is asserted.
- `RND_W`, default 5: width of the round index; must satisfy 2^RND_W >= ROUNDS.

Ports:
- `clk`  in  1  single clock; all state is on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `flush`  in  1  synchronous clear of all buffered entries.
- `in_valid`  in  1  an input beat is offered.
- `in_ready`  out  1  the stage can accept a beat; driven directly from a register.
- `in_block`  in  64  block words `{R0,R1,R2,R3}`, with R0 in bits [63:48].
- `in_key`  in  48  round key `{K0,K1,K2}`, with K0 in bits [47:32].
- `in_round`  in  RND_W  round index, 0..ROUNDS-1.
- `out_valid`  out  1  an output beat is present.
- `out_ready`  in  1  the downstream stage accepts the beat.
- `out_data`  out  48  mixed control bits; feeds the P-box.
- `out_block`  out  64  the block, passed through unchanged.
- `out_round`  out  RND_W  the round index, passed through.
- `out_last`  out  1  high when `out_round == ROUNDS-1`.

## Operation
- Mixing is done on the input side and registered with the entry:
  - `data[47:32] = R1 ^ K0`
  - `data[31:16] = R2 ^ K1`
  - `data[15:0] = R3 ^ K2`
- R0 is the target word and is not mixed. It travels only inside `out_block`.
- Storage is a 2-entry FIFO: head register, tail register, and a 2-bit occupancy count 0..2.
- Push happens when `in_valid && in_ready && !flush`.
- Pop happens when `out_valid && out_ready && !flush`.
- Occupancy states and transitions:
  - EMPTY (0): push goes to FULL1.
  - FULL1 (1): push alone goes to FULL2; pop alone goes to EMPTY; push and pop together stay in FULL1, with the new entry becoming the head.
  - FULL2 (2): pop goes to FULL1 and the tail moves to the head. No push is possible.
- `in_ready` is registered and equals `(count_next < 2) && !flush_q`. In FULL2 it is low, so a beat offered there is never captured.
- `out_valid = (count != 0)`. The `out_*` fields come from the head register.
- `flush` has priority over push and pop in the same cycle. Count goes to 0 and any offered beat is dropped. `in_ready` is low in the cycle after `flush`.
- Order is preserved strictly. No beat is duplicated or dropped except by `flush` or reset.
- `out_last` is combinational from `out_round`. `in_round >= ROUNDS` is passed through unchanged and gives `out_last = 0`.

## Timing
- Reset values (asynchronous assert, synchronous release):
  - count = 0
  - `out_valid = 0`
  - `in_ready = 0` in the first cycle after release, then 1
  - `out_data`, `out_block`, `out_round` = 0
  - `out_last` = 1 only if ROUNDS==1, otherwise 0
- Latency is 1 cycle. A beat accepted at edge N is presented on `out_*` after edge N, whenever it is the head.
- Throughput is 1 beat/cycle with `out_ready` held high.
- When `out_ready` drops, the stage absorbs one more beat and then `in_ready` falls.
- `out_*` stays stable while `out_valid && !out_ready`.
- Reset asserted mid-transfer discards all entries immediately.

## Configuration
- `MACGUFFIN_KEY_MIX_ZEROIZE_EN`
  - **Defined:** a popped or flushed entry register is cleared to 0. `out_data`, `out_block` and `out_round` read 0 whenever `out_valid` is low, so no key-dependent value lingers.
  - **Undefined:** entry registers keep stale contents after pop or flush, and `out_*` is don't-care while `out_valid` is low. Handshake behaviour is identical in both builds.

## Test plan
- **Single beat:** `in_block = 64'h0123_4567_89AB_CDEF`, `in_key = 48'hFFFF_0000_1234`, `in_round = 3`, `out_ready = 1`. The next cycle must show `out_data = 48'hBA98_89AB_DFDB`, the block unchanged, `out_round = 3`, `out_last = 0`.
- **Backpressure:** stream 4 beats with rounds 28..31 while `out_ready = 0`. `in_ready` must fall after 2 accepts. After releasing `out_ready`, all 4 beats must drain in order, and `out_last = 1` only on round 31.
- **Simultaneous push/pop in FULL1:** 10 beats with `out_ready = 1` must give 10 outputs at 1/cycle in order, with count never reaching 2.
- **Flush in FULL2 with `in_valid` high:** `out_valid = 0` next cycle, the offered beat never appears, and `in_ready` is low for 1 cycle and then high.
- **Async reset mid-stream in FULL2:** asserting `rst_n = 0` between edges must force `out_valid = 0` immediately. After release, nothing is output until a new beat arrives.
- **Zeroize build:** after the last pop, `out_data`, `out_block` and `out_round` must read 0. In the non-zeroize build the same test checks only the handshake.
